// File: rtl/afu_if_pkg.sv
// Shared widths and request types for the AFU SPL request/response interface.
// The write request packs the fence flag above address and data so a single FIFO carries both kinds of beat.
package afu_if_pkg;

  localparam int CL_W   = 512;
  localparam int ADDR_W = 58;

  typedef struct packed {
    logic              fence;
    logic [ADDR_W-1:0] addr;
    logic [CL_W-1:0]   data;
  } wr_req_t;

  localparam int WR_REQ_W = $bits(wr_req_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push to a full FIFO is dropped and flagged on `drop`,
// unless a pop happens in the same cycle, which frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             CLK_400M,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             drop
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign head    = store[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_400M) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which entries are valid,
  // and a reset term on the array would prevent it from mapping onto RAM.
  always_ff @(posedge CLK_400M) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/afu_mem_responder.sv
// Host-side SPL endpoint: in-order read responses from a local line memory, write/fence absorption,
// and almostfull back-pressure. Reads stall while any fence is still queued behind earlier writes.
module afu_mem_responder
  import afu_if_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int FIFO_AW    = 4,
  parameter int AF_THRESH  = 12,
  parameter int RD_LATENCY = 4
) (
  input  logic              CLK_400M,
  input  logic              reset_n,
  input  logic              cor_tx_rd_valid,
  input  logic [ADDR_W-1:0] cor_tx_rd_addr,
  output logic              spl_tx_rd_almostfull,
  input  logic              cor_tx_wr_valid,
  input  logic              cor_tx_fence_valid,
  input  logic [ADDR_W-1:0] cor_tx_wr_addr,
  input  logic [CL_W-1:0]   cor_tx_data,
  output logic              spl_tx_wr_almostfull,
  output logic              io_rx_rd_valid,
  output logic [CL_W-1:0]   io_rx_data,
  input  logic              bd_wr_en,
  input  logic [MEM_AW-1:0] bd_wr_addr,
  input  logic [CL_W-1:0]   bd_wr_data,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [15:0]       fence_count,
  output logic              overflow_err
);

  localparam int CNT_W = FIFO_AW + 1;
  localparam int LINES = 1 << MEM_AW;

  logic              rd_empty;
  logic              rd_full;
  logic              rd_pop;
  logic              rd_drop;
  logic [CNT_W-1:0]  rd_occ;
  logic [ADDR_W-1:0] rd_head;

  logic              wr_empty;
  logic              wr_full;
  logic              wr_pop;
  logic              wr_drop;
  logic [CNT_W-1:0]  wr_occ;
  wr_req_t           wr_push_req;
  wr_req_t           wr_head;

  logic [CNT_W-1:0]  fence_pend;
  logic              fence_push;
  logic              fence_retire;

  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [CL_W-1:0]   mem_wdata;
  logic [MEM_AW-1:0] rd_idx;
  logic [CL_W-1:0]   rd_word;
  logic [CL_W-1:0]   mem [LINES];

  logic [RD_LATENCY:0] pipe_vld;
  logic [CL_W-1:0]     pipe_data [RD_LATENCY+1];

  logic              unused_bits;

  assign wr_push_req = '{fence: cor_tx_fence_valid, addr: cor_tx_wr_addr, data: cor_tx_data};

  sync_fifo #(.WIDTH(ADDR_W), .AW(FIFO_AW)) u_rd_fifo (
    .CLK_400M  (CLK_400M),
    .reset_n   (reset_n),
    .push      (cor_tx_rd_valid),
    .push_data (cor_tx_rd_addr),
    .pop       (rd_pop),
    .head      (rd_head),
    .full      (rd_full),
    .empty     (rd_empty),
    .count     (rd_occ),
    .drop      (rd_drop)
  );

  sync_fifo #(.WIDTH(WR_REQ_W), .AW(FIFO_AW)) u_wr_fifo (
    .CLK_400M  (CLK_400M),
    .reset_n   (reset_n),
    .push      (cor_tx_wr_valid),
    .push_data (wr_push_req),
    .pop       (wr_pop),
    .head      (wr_head),
    .full      (wr_full),
    .empty     (wr_empty),
    .count     (wr_occ),
    .drop      (wr_drop)
  );

  // A queued fence holds back every read so reads observe all writes ahead of it.
  assign rd_pop       = !rd_empty && (fence_pend == '0);
  assign wr_pop       = reset_n && !wr_empty && !bd_wr_en;
  assign fence_push   = cor_tx_wr_valid && cor_tx_fence_valid && !wr_drop;
  assign fence_retire = wr_pop && wr_head.fence;

  assign spl_tx_rd_almostfull = (rd_occ >= CNT_W'(AF_THRESH));
  assign spl_tx_wr_almostfull = (wr_occ >= CNT_W'(AF_THRESH));

  // Backdoor preload owns the write port; the FIFO commit simply waits a cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    mem_we    = 1'b0;
    mem_waddr = wr_head.addr[MEM_AW-1:0];
    mem_wdata = wr_head.data;
    if (bd_wr_en) begin
      mem_we    = 1'b1;
      mem_waddr = bd_wr_addr;
      mem_wdata = bd_wr_data;
    end else if (wr_pop && !wr_head.fence) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge CLK_400M) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Write-first: a read of the line being written this cycle sees the new data.
  assign rd_idx  = rd_head[MEM_AW-1:0];
  assign rd_word = (mem_we && (mem_waddr == rd_idx)) ? mem_wdata : mem[rd_idx];

  always_ff @(posedge CLK_400M) begin
    if (!reset_n) begin
      fence_pend   <= '0;
      rd_count     <= '0;
      wr_count     <= '0;
      fence_count  <= '0;
      overflow_err <= 1'b0;
    end else begin
      fence_pend <= fence_pend + CNT_W'(fence_push) - CNT_W'(fence_retire);
      if (cor_tx_rd_valid && !rd_drop)  rd_count    <= rd_count + 32'd1;
      if (wr_pop && !wr_head.fence)     wr_count    <= wr_count + 32'd1;
      if (fence_retire)                 fence_count <= fence_count + 16'd1;
      if (rd_drop || wr_drop)           overflow_err <= 1'b1;
    end
  end

  // Read capture stage, RD_LATENCY delay stages, then the registered output.
  always_ff @(posedge CLK_400M) begin
    if (!reset_n) begin
      pipe_vld       <= '0;
      io_rx_rd_valid <= 1'b0;
      io_rx_data     <= '0;
    end else begin
      pipe_vld       <= {pipe_vld[RD_LATENCY-1:0], rd_pop};
      io_rx_rd_valid <= pipe_vld[RD_LATENCY];
      io_rx_data     <= pipe_data[RD_LATENCY];
    end
  end

  always_ff @(posedge CLK_400M) begin
    pipe_data[0] <= rd_word;
    for (int i = 1; i <= RD_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  // Upper address bits alias onto the line index; full is implied by drop.
  assign unused_bits = ^{rd_full, wr_full, rd_head[ADDR_W-1:MEM_AW], wr_head.addr[ADDR_W-1:MEM_AW]};

endmodule

// File: tb/tb_afu_mem_responder.sv
// Bench for afu_mem_responder: queue-based reference model checked every cycle, plus directed
// scenarios with hand-derived expectations, followed by randomized traffic.
module tb_afu_mem_responder;

  localparam int MEM_AW     = 10;
  localparam int FIFO_AW    = 4;
  localparam int AF_THRESH  = 12;
  localparam int RD_LATENCY = 4;
  localparam int DEPTH      = 1 << FIFO_AW;

  logic         CLK_400M = 1'b0;
  logic         reset_n  = 1'b0;
  logic         cor_tx_rd_valid = 1'b0;
  logic [57:0]  cor_tx_rd_addr = '0;
  logic         spl_tx_rd_almostfull;
  logic         cor_tx_wr_valid = 1'b0;
  logic         cor_tx_fence_valid = 1'b0;
  logic [57:0]  cor_tx_wr_addr = '0;
  logic [511:0] cor_tx_data = '0;
  logic         spl_tx_wr_almostfull;
  logic         io_rx_rd_valid;
  logic [511:0] io_rx_data;
  logic         bd_wr_en = 1'b0;
  logic [9:0]   bd_wr_addr = '0;
  logic [511:0] bd_wr_data = '0;
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
  logic [15:0]  fence_count;
  logic         overflow_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  afu_mem_responder #(
    .MEM_AW(MEM_AW), .FIFO_AW(FIFO_AW), .AF_THRESH(AF_THRESH), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .CLK_400M             (CLK_400M),
    .reset_n              (reset_n),
    .cor_tx_rd_valid      (cor_tx_rd_valid),
    .cor_tx_rd_addr       (cor_tx_rd_addr),
    .spl_tx_rd_almostfull (spl_tx_rd_almostfull),
    .cor_tx_wr_valid      (cor_tx_wr_valid),
    .cor_tx_fence_valid   (cor_tx_fence_valid),
    .cor_tx_wr_addr       (cor_tx_wr_addr),
    .cor_tx_data          (cor_tx_data),
    .spl_tx_wr_almostfull (spl_tx_wr_almostfull),
    .io_rx_rd_valid       (io_rx_rd_valid),
    .io_rx_data           (io_rx_data),
    .bd_wr_en             (bd_wr_en),
    .bd_wr_addr           (bd_wr_addr),
    .bd_wr_data           (bd_wr_data),
    .rd_count             (rd_count),
    .wr_count             (wr_count),
    .fence_count          (fence_count),
    .overflow_err         (overflow_err)
  );

  always #2 CLK_400M = ~CLK_400M;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic fence; logic [57:0] addr; logic [511:0] data; } m_wr_t;
  typedef struct { longint due; logic [511:0] data; } m_resp_t;

  longint       cyc = 0;
  logic [511:0] m_mem [1 << MEM_AW];
  logic [57:0]  m_rq [$];
  m_wr_t        m_wq [$];
  m_resp_t      m_resp [$];
  logic [31:0]  m_rc = '0;
  logic [31:0]  m_wc = '0;
  logic [15:0]  m_fc = '0;
  logic         m_ovf = 1'b0;
  logic         exp_valid = 1'b0;
  logic [511:0] exp_data = '0;

  always @(posedge CLK_400M) begin
    int      nf;
    bit      rpop;
    bit      wpop;
    m_wr_t   h;
    m_wr_t   w;
    m_resp_t r;
    logic [57:0] a;
    cyc++;
    if (bd_wr_en) m_mem[bd_wr_addr] = bd_wr_data;
    if (!reset_n) begin
      m_rq.delete();
      m_wq.delete();
      m_resp.delete();
      m_rc = '0; m_wc = '0; m_fc = '0; m_ovf = 1'b0;
    end else begin
      nf = 0;
      foreach (m_wq[i]) if (m_wq[i].fence) nf++;
      rpop = (m_rq.size() != 0) && (nf == 0);
      wpop = (m_wq.size() != 0) && !bd_wr_en;
      if (wpop) begin
        h = m_wq.pop_front();
        if (h.fence) m_fc++;
        else begin
          m_mem[h.addr[MEM_AW-1:0]] = h.data;
          m_wc++;
        end
      end
      if (rpop) begin
        a = m_rq.pop_front();
        r.due  = cyc + RD_LATENCY + 1;
        r.data = m_mem[a[MEM_AW-1:0]];
        m_resp.push_back(r);
      end
      if (cor_tx_rd_valid) begin
        if (m_rq.size() < DEPTH) begin m_rq.push_back(cor_tx_rd_addr); m_rc++; end
        else m_ovf = 1'b1;
      end
      if (cor_tx_wr_valid) begin
        w.fence = cor_tx_fence_valid; w.addr = cor_tx_wr_addr; w.data = cor_tx_data;
        if (m_wq.size() < DEPTH) m_wq.push_back(w);
        else m_ovf = 1'b1;
      end
    end
    exp_valid = 1'b0;
    if (m_resp.size() != 0 && m_resp[0].due == cyc) begin
      exp_valid = 1'b1;
      exp_data  = m_resp[0].data;
      void'(m_resp.pop_front());
    end
  end

  always @(negedge CLK_400M) begin
    if (chk_en) begin
      check("rx_valid", 512'(io_rx_rd_valid), 512'(exp_valid));
      if (exp_valid) check("rx_data", io_rx_data, exp_data);
      check("rd_count", 512'(rd_count), 512'(m_rc));
      check("wr_count", 512'(wr_count), 512'(m_wc));
      check("fence_count", 512'(fence_count), 512'(m_fc));
      check("overflow_err", 512'(overflow_err), 512'(m_ovf));
      check("rd_almostfull", 512'(spl_tx_rd_almostfull), 512'(m_rq.size() >= AF_THRESH));
      check("wr_almostfull", 512'(spl_tx_wr_almostfull), 512'(m_wq.size() >= AF_THRESH));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [57:0] rand_addr(input int max_idx);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[MEM_AW-1:0] = MEM_AW'($urandom_range(0, max_idx));
    return r[57:0];
  endfunction

  task automatic cycle();
    @(negedge CLK_400M);
  endtask

  task automatic clear_inputs();
    cor_tx_rd_valid = 1'b0; cor_tx_wr_valid = 1'b0; cor_tx_fence_valid = 1'b0; bd_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    cycle(); cycle();
    reset_n = 1'b1;
  endtask

  task automatic bd_write(input int idx, input logic [511:0] d);
    bd_wr_en = 1'b1; bd_wr_addr = 10'(idx); bd_wr_data = d;
    cycle();
    bd_wr_en = 1'b0;
  endtask

  task automatic wait_resp(output bit seen, output logic [511:0] d);
    seen = 1'b0; d = '0;
    for (int i = 0; i < 40; i++) begin
      if (io_rx_rd_valid) begin seen = 1'b1; d = io_rx_data; break; end
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] va, vb, vc, vd, ve, vf, vg, fd, d;
    logic [57:0]  alias_addr;
    longint       t0;
    int           lat;
    int           nresp;
    bit           seen;
    int           mode;

    cycle(); cycle();
    chk_en = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < (1 << MEM_AW); i++) bd_write(i, rand512());

    // 1: two back-to-back reads on an idle path
    va = rand512(); vb = rand512();
    bd_write(5, va); bd_write(6, vb);
    cor_tx_rd_valid = 1'b1; cor_tx_rd_addr = 58'd5;
    cycle();
    t0 = cyc;
    cor_tx_rd_addr = 58'd6;
    cycle();
    cor_tx_rd_valid = 1'b0;
    lat = -1; d = '0;
    for (int i = 0; i < 20; i++) begin
      if (io_rx_rd_valid) begin lat = int'(cyc - t0); d = io_rx_data; break; end
      cycle();
    end
    check("t1_latency_a", 512'(lat), 512'(6));
    check("t1_data_a", d, va);
    cycle();
    check("t1_latency_b", 512'(cyc - t0), 512'(7));
    check("t1_valid_b", 512'(io_rx_rd_valid), 512'(1));
    check("t1_data_b", io_rx_data, vb);

    // 2: fill the read FIFO behind a fence held in the write FIFO
    do_reset();
    fd = rand512(); fd[511] = 1'b1;
    bd_wr_en = 1'b1; bd_wr_addr = 10'd100; bd_wr_data = rand512();
    cor_tx_wr_valid = 1'b1; cor_tx_fence_valid = 1'b1; cor_tx_wr_addr = '0; cor_tx_data = fd;
    cycle();
    cor_tx_wr_valid = 1'b0; cor_tx_fence_valid = 1'b0;
    cor_tx_rd_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cor_tx_rd_addr = rand_addr(1023);
      cycle();
      if (i == 11) check("t2_af_at_11", 512'(spl_tx_rd_almostfull), 512'(0));
      if (i == 12) check("t2_af_at_12", 512'(spl_tx_rd_almostfull), 512'(1));
      if (i == 16) check("t2_ovf_at_16", 512'(overflow_err), 512'(0));
      if (i == 17) check("t2_ovf_at_17", 512'(overflow_err), 512'(1));
    end
    cor_tx_rd_valid = 1'b0;
    bd_wr_en = 1'b0;
    nresp = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (io_rx_rd_valid) nresp++;
    end
    check("t2_responses", 512'(nresp), 512'(16));
    check("t2_rd_count", 512'(rd_count), 512'(16));
    check("t2_fence_count", 512'(fence_count), 512'(1));

    // 3: write, fence, read of the same line
    do_reset();
    vc = rand512();
    cor_tx_wr_valid = 1'b1; cor_tx_wr_addr = 58'd7; cor_tx_data = vc;
    cycle();
    cor_tx_fence_valid = 1'b1; cor_tx_wr_addr = '0; cor_tx_data = fd;
    cycle();
    cor_tx_wr_valid = 1'b0; cor_tx_fence_valid = 1'b0;
    cor_tx_rd_valid = 1'b1; cor_tx_rd_addr = 58'd7;
    cycle();
    cor_tx_rd_valid = 1'b0;
    wait_resp(seen, d);
    check("t3_seen", 512'(seen), 512'(1));
    check("t3_data", d, vc);
    check("t3_fence_count", 512'(fence_count), 512'(1));
    check("t3_wr_count", 512'(wr_count), 512'(1));

    // 4: a fence beat addressed at line 0 must not disturb it
    vd = rand512();
    bd_write(0, vd);
    cor_tx_wr_valid = 1'b1; cor_tx_fence_valid = 1'b1; cor_tx_wr_addr = '0; cor_tx_data = fd;
    cycle();
    clear_inputs();
    cycle(); cycle(); cycle();
    cor_tx_rd_valid = 1'b1; cor_tx_rd_addr = '0;
    cycle();
    cor_tx_rd_valid = 1'b0;
    wait_resp(seen, d);
    check("t4_data", d, vd);

    // 5: write commit and read pop of line 9 in the same cycle
    vf = rand512(); ve = rand512();
    bd_write(9, vf);
    cycle(); cycle();
    cor_tx_wr_valid = 1'b1; cor_tx_wr_addr = 58'd9; cor_tx_data = ve;
    cor_tx_rd_valid = 1'b1; cor_tx_rd_addr = 58'd9;
    cycle();
    clear_inputs();
    wait_resp(seen, d);
    check("t5_data", d, ve);

    // 6: reset with reads in flight, then an aliased read
    cor_tx_rd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin cor_tx_rd_addr = rand_addr(1023); cycle(); end
    cor_tx_rd_valid = 1'b0;
    reset_n = 1'b0;
    cycle(); cycle();
    reset_n = 1'b1;
    check("t6_rd_count", 512'(rd_count), 512'(0));
    check("t6_wr_count", 512'(wr_count), 512'(0));
    check("t6_fence_count", 512'(fence_count), 512'(0));
    check("t6_rd_af", 512'(spl_tx_rd_almostfull), 512'(0));
    check("t6_wr_af", 512'(spl_tx_wr_almostfull), 512'(0));
    nresp = 0;
    for (int i = 0; i < 20; i++) begin
      if (io_rx_rd_valid) nresp++;
      cycle();
    end
    check("t6_no_resp", 512'(nresp), 512'(0));
    vg = rand512();
    bd_write(3, vg);
    alias_addr = (58'd1 << MEM_AW) | 58'd3;
    cor_tx_rd_valid = 1'b1; cor_tx_rd_addr = alias_addr;
    cycle();
    cor_tx_rd_valid = 1'b0;
    wait_resp(seen, d);
    check("t6_alias_data", d, vg);

    // randomized traffic, checked by the model every cycle
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) mode = $urandom_range(0, 2);
      reset_n            = ($urandom_range(0, 1499) != 0);
      cor_tx_rd_valid    = ($urandom_range(0, 99) < ((mode == 2) ? 20 : 55));
      cor_tx_rd_addr     = rand_addr(15);
      cor_tx_wr_valid    = ($urandom_range(0, 99) < ((mode == 2) ? 15 : 40));
      cor_tx_fence_valid = cor_tx_wr_valid && ($urandom_range(0, 9) == 0);
      cor_tx_wr_addr     = rand_addr(15);
      cor_tx_data        = rand512();
      bd_wr_en           = ($urandom_range(0, 99) < ((mode == 1) ? 80 : 5));
      bd_wr_addr         = 10'($urandom_range(0, 15));
      bd_wr_data         = rand512();
      cycle();
    end
    clear_inputs();
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
